imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader_uart_rx_core.sv | 110 +++++++++++
 rtl/imem_loader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
//   byte_t     : 8-bit byte type used on the receiver/loader boundary
//   SYNC_BYTE  : frame start marker
//   state_t    : loader frame-parsing states
//   rx_state_t : UART bit-receiver states
package imem_loader_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/imem_loader_uart_rx_core.sv
// 8N1 UART byte receiver.
//   clk, reset : system clock, synchronous active-high reset
//   rx         : asynchronous serial input, idle high
//   byte_valid : one-cycle pulse, byte_data holds the received byte
//   byte_data  : last received byte (LSB received first)
//   frame_err  : one-cycle pulse when the stop bit is sampled low
module uart_rx_core
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t       rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    byte_t           shift_reg, shift_next;
    logic            byte_valid_reg, byte_valid_next;
    logic            frame_err_reg, frame_err_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            rx_prev_reg    <= 1'b1;
            rx_state_reg   <= RX_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_meta_reg    <= rx;
            rx_sync_reg    <= rx_meta_reg;
            rx_prev_reg    <= rx_sync_reg;
            rx_state_reg   <= rx_state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        rx_state_next   = rx_state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        unique case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_state_next = RX_START;
                    cnt_next      = '0;
                end
            end
            RX_START: begin
                // Mid-start-bit re-check rejects short glitches.
                if (cnt_reg == HALF_M1) begin
                    cnt_next      = '0;
                    bit_idx_next  = '0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_reg == BIT_M1) begin
                    cnt_next     = '0;
                    shift_next   = {rx_sync_reg, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_reg == BIT_M1) begin
                    cnt_next        = '0;
                    byte_valid_next = rx_sync_reg;
                    frame_err_next  = !rx_sync_reg;
                    rx_state_next   = RX_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign byte_valid = byte_valid_reg;
    assign byte_data  = shift_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: rtl/imem_loader.sv
// UART boot loader: receives a framed program image and writes it into
// instruction memory, holding the CPU in reset until a good load completes.
//   clk, reset  : system clock, synchronous active-high reset
//   rx          : UART serial input (8N1, idle high)
//   imem_we     : one-cycle write strobe
//   imem_addr   : word address of the write (held between writes)
//   imem_wdata  : instruction word (held between writes)
//   cpu_hold    : 1 except after a load completed with a good checksum
//   done / err  : result of the last load (mutually exclusive)
// Frame: A5, N low, N high, 4*N little-endian payload bytes, XOR checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam logic [16:0] DEPTH = 17'(1 << ADDR_WIDTH);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    state_t                state_reg, state_next;
    logic [15:0]           len_reg, len_next;
    logic [1:0]            byte_cnt_reg, byte_cnt_next;
    logic [31:0]           word_buf_reg, word_buf_next;
    logic [ADDR_WIDTH:0]   word_idx_reg, word_idx_next;
    byte_t                 chk_reg, chk_next;
    logic                  we_reg, we_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;
    logic [15:0]           len_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            len_reg      <= '0;
            byte_cnt_reg <= '0;
            word_buf_reg <= '0;
            word_idx_reg <= '0;
            chk_reg      <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            byte_cnt_reg <= byte_cnt_next;
            word_buf_reg <= word_buf_next;
            word_idx_reg <= word_idx_next;
            chk_reg      <= chk_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    assign len_full = {byte_data, len_reg[7:0]};

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        byte_cnt_next = byte_cnt_reg;
        word_buf_next = word_buf_reg;
        word_idx_next = word_idx_reg;
        chk_next      = chk_reg;
        we_next       = 1'b0;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        done_next     = done_reg;
        err_next      = err_reg;

        if (frame_err && (state_reg inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK})) begin
            state_next = ST_ERROR;
            done_next  = 1'b0;
            err_next   = 1'b1;
        end else if (byte_valid) begin
            unique case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (byte_data == SYNC_BYTE) begin
                        state_next    = ST_LEN_LO;
                        done_next     = 1'b0;
                        err_next      = 1'b0;
                        word_idx_next = '0;
                        chk_next      = '0;
                        byte_cnt_next = '0;
                    end
                end
                ST_LEN_LO: begin
                    len_next[7:0] = byte_data;
                    state_next    = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    len_next = len_full;
                    if (len_full == 16'd0) begin
                        state_next = ST_CHK;
                    end else if ({1'b0, len_full} > DEPTH) begin
                        state_next = ST_ERROR;
                        err_next   = 1'b1;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    chk_next      = chk_reg ^ byte_data;
                    byte_cnt_next = byte_cnt_reg + 1'b1;
                    word_buf_next[byte_cnt_reg*8 +: 8] = byte_data;
                    if (byte_cnt_reg == 2'd3) begin
                        // Write strobe and address/data are registered, so the
                        // write appears the cycle after the 4th byte.
                        we_next       = 1'b1;
                        addr_next     = word_idx_reg[ADDR_WIDTH-1:0];
                        wdata_next    = {byte_data, word_buf_reg[23:0]};
                        word_idx_next = word_idx_reg + 1'b1;
                        if ((17'(word_idx_reg) + 17'd1) == {1'b0, len_reg}) begin
                            state_next = ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (byte_data == chk_reg) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_ERROR;
                        err_next   = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign cpu_hold   = (state_reg != ST_DONE);
    assign done       = done_reg;
    assign err        = err_reg;

endmodule
